// File: rtl/fm_mult_sched_pkg.sv
// fm_pkg: shared FSM state, bus widths and product slice positions for fm_mult_sched
package fm_pkg;
    typedef enum logic [1:0] {IDLE, OP_FM, OP_D, OP_MIX} state_e;
    localparam int FREQ_W  = 24;
    localparam int DSP_A_W = 24;
    localparam int DSP_B_W = 18;
    localparam int DSP_P_W = 48;
    localparam int DEPTH_W = 18;
    // mod_freq = P[37:14], depth = P[29:12], mixed_freq = P[44:21]
    localparam int MF_LSB  = 14;
    localparam int D_LSB   = 12;
    localparam int MX_LSB  = 21;
endpackage

// File: rtl/fm_mult_sched_if.sv
// fm_mult_sched_if: operand/product bus to the shared DSP48 macro (P = A*B + C)
//   master: drives dsp_a/dsp_b/dsp_c, receives dsp_p
//   slave : the DSP macro side
interface fm_mult_sched_if;
    import fm_pkg::*;
    logic [DSP_A_W-1:0] dsp_a;
    logic [DSP_B_W-1:0] dsp_b;
    logic [DSP_P_W-1:0] dsp_c;
    logic [DSP_P_W-1:0] dsp_p;
    modport master (output dsp_a, dsp_b, dsp_c, input dsp_p);
    modport slave (input dsp_a, dsp_b, dsp_c, output dsp_p);
endinterface

// File: rtl/fm_mult_sched.sv
// fm_mult_sched: schedules the three multiplies of one FM sample onto a shared DSP48
//   clk, reset (sync, active-low)
//   sample_tick, fundamental (14.10), harmonicity (3.13), mod_index (7.9), mod_sig (0.24)
//   dsp            : operand/product bus to the external DSP macro
//   mod_freq, mixed_freq (15.9) with one-cycle valid strobes, busy, sticky overrun
module fm_mult_sched
    import fm_pkg::*;
#(
    parameter int DSP_LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_tick,
    input  logic [FREQ_W-1:0] fundamental,
    input  logic [15:0]       harmonicity,
    input  logic [15:0]       mod_index,
    input  logic [FREQ_W-1:0] mod_sig,
    fm_mult_sched_if.master   dsp,
    output logic [FREQ_W-1:0] mod_freq,
    output logic [FREQ_W-1:0] mixed_freq,
    output logic              mod_freq_valid,
    output logic              mixed_freq_valid,
    output logic              busy,
    output logic              overrun
);
    localparam int CW = $clog2(DSP_LATENCY + 2);
    localparam logic [CW-1:0] LAST = CW'(DSP_LATENCY);

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [FREQ_W-1:0]   fund_q, mod_sig_q, mod_freq_q, mixed_q;
    logic [15:0]         harm_q, mi_q;
    logic [DEPTH_W-1:0]  depth_q;
    logic                mfv_q, mxv_q, busy_q, ovr_q;
    logic [DSP_P_W-1:0]  p;
    logic                unused_p;

    assign p        = dsp.dsp_p;
    assign unused_p = ^{p[DSP_P_W-1:MX_LSB+FREQ_W], p[D_LSB-1:0]};

    // Operands are decoded from registered state and snapshots, so they stay
    // constant for the whole op and each new op sees the freshly captured result.
    assign dsp.dsp_a = state_q == OP_FM  ? fund_q :
                       state_q == OP_D   ? mod_freq_q :
                       state_q == OP_MIX ? mod_sig_q : '0;
    assign dsp.dsp_b = state_q == OP_FM  ? {2'b0, harm_q} :
                       state_q == OP_D   ? {2'b0, mi_q} :
                       state_q == OP_MIX ? depth_q : '0;
    assign dsp.dsp_c = state_q == OP_MIX ? {4'b0, fund_q, 20'b0} : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            fund_q     <= '0;
            harm_q     <= '0;
            mi_q       <= '0;
            mod_sig_q  <= '0;
            depth_q    <= '0;
            mod_freq_q <= '0;
            mixed_q    <= '0;
            mfv_q      <= 1'b0;
            mxv_q      <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            mfv_q <= 1'b0;
            mxv_q <= 1'b0;
            if (state_q == IDLE) begin
                if (sample_tick) begin
                    state_q   <= OP_FM;
                    cnt_q     <= '0;
                    busy_q    <= 1'b1;
                    fund_q    <= fundamental;
                    harm_q    <= harmonicity;
                    mi_q      <= mod_index;
                    mod_sig_q <= mod_sig;
                end
            end else begin
                if (sample_tick)
                    ovr_q <= 1'b1;
                cnt_q <= cnt_q == LAST ? '0 : cnt_q + 1'b1;
                // dsp_p reflects this op's operands only once the pipe has filled
                if (cnt_q == LAST) begin
                    case (state_q)
                        OP_FM: begin
                            mod_freq_q <= p[MF_LSB +: FREQ_W];
                            mfv_q      <= 1'b1;
                            state_q    <= OP_D;
                        end
                        OP_D: begin
                            depth_q <= p[D_LSB +: DEPTH_W];
                            state_q <= OP_MIX;
                        end
                        default: begin
                            mixed_q <= p[MX_LSB +: FREQ_W];
                            mxv_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign mod_freq         = mod_freq_q;
    assign mixed_freq       = mixed_q;
    assign mod_freq_valid   = mfv_q;
    assign mixed_freq_valid = mxv_q;
    assign busy             = busy_q;
    assign overrun          = ovr_q;
endmodule

// File: tb/tb_fm_mult_sched.sv
// tb_fm_mult_sched: randomized self-checking bench for fm_mult_sched with a behavioural DSP48 model
module tb_fm_mult_sched;
    localparam int L = 3;
    localparam int N = 3 * L + 4;

    logic        clk = 1'b0, reset = 1'b0, sample_tick = 1'b0;
    logic [23:0] fundamental = '0, mod_sig = '0;
    logic [15:0] harmonicity = '0, mod_index = '0;
    logic [23:0] mod_freq, mixed_freq;
    logic        mod_freq_valid, mixed_freq_valid, busy, overrun;

    int          n_tests = 0, n_fail = 0;
    logic [23:0] prev_mf = '0, prev_mx = '0;
    logic        exp_ovr = 1'b0;

    fm_mult_sched_if dsp ();
    logic [47:0] pipe [L];

    fm_mult_sched #(.DSP_LATENCY(L)) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick),
        .fundamental(fundamental), .harmonicity(harmonicity),
        .mod_index(mod_index), .mod_sig(mod_sig), .dsp(dsp.master),
        .mod_freq(mod_freq), .mixed_freq(mixed_freq),
        .mod_freq_valid(mod_freq_valid), .mixed_freq_valid(mixed_freq_valid),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // DSP48 stand-in: P = A*B + C with L cycles of latency
    always @(posedge clk) begin
        pipe[0] <= 48'(longint'(dsp.dsp_a) * longint'(dsp.dsp_b) + longint'(dsp.dsp_c));
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign dsp.dsp_p = pipe[L-1];

    function automatic logic [23:0] ref_mf(input logic [23:0] f, input logic [15:0] h);
        return 24'((longint'(f) * longint'(h)) >> 14);
    endfunction

    function automatic logic [23:0] ref_mx(input logic [23:0] f, input logic [15:0] h,
                                           input logic [15:0] mi, input logic [23:0] ms);
        longint mf, d;
        mf = longint'(ref_mf(f, h));
        d  = ((mf * longint'(mi)) >> 12) & 64'h3FFFF;
        return 24'((longint'(ms) * d + (longint'(f) << 20)) >> 21);
    endfunction

    // Caller is at a negedge; the tick is raised here, in "cycle 0".
    task automatic run_sample(input logic [23:0] f, input logic [15:0] h, input logic [15:0] mi,
                              input logic [23:0] ms, input int xtick, input int chg, input string nm);
        logic [23:0] emf, emx;
        bit pend = 0;
        emf = ref_mf(f, h);
        emx = ref_mx(f, h, mi, ms);
        fundamental = f; harmonicity = h; mod_index = mi; mod_sig = ms;
        sample_tick = 1'b1;
        for (int k = 1; k <= N; k++) begin
            @(negedge clk);
            sample_tick = 1'b0;
            if (pend) exp_ovr = 1'b1;
            pend = 0;
            n_tests++;
            if (busy !== (k < N)) begin n_fail++; $display("FAIL %s busy c%0d got %b want %b", nm, k, busy, k < N); end
            n_tests++;
            if (mod_freq_valid !== (k == L + 2)) begin n_fail++; $display("FAIL %s mf_valid c%0d got %b", nm, k, mod_freq_valid); end
            n_tests++;
            if (mixed_freq_valid !== (k == N)) begin n_fail++; $display("FAIL %s mx_valid c%0d got %b", nm, k, mixed_freq_valid); end
            n_tests++;
            if (mod_freq !== (k >= L + 2 ? emf : prev_mf)) begin n_fail++; $display("FAIL %s mod_freq c%0d got %h want %h", nm, k, mod_freq, k >= L + 2 ? emf : prev_mf); end
            n_tests++;
            if (mixed_freq !== (k >= N ? emx : prev_mx)) begin n_fail++; $display("FAIL %s mixed_freq c%0d got %h want %h", nm, k, mixed_freq, k >= N ? emx : prev_mx); end
            n_tests++;
            if (overrun !== exp_ovr) begin n_fail++; $display("FAIL %s overrun c%0d got %b want %b", nm, k, overrun, exp_ovr); end
            if (k == xtick) begin sample_tick = 1'b1; pend = 1; end
            if (k == chg) begin
                fundamental = 24'($urandom); harmonicity = 16'($urandom);
                mod_index = 16'($urandom); mod_sig = 24'($urandom);
            end
        end
        prev_mf = emf;
        prev_mx = emx;
    endtask

    task automatic idle(input int n, input string nm);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            sample_tick = 1'b0;
            n_tests++;
            if (busy !== 1'b0 || mod_freq_valid !== 1'b0 || mixed_freq_valid !== 1'b0) begin
                n_fail++; $display("FAIL %s idle flags got busy=%b mfv=%b mxv=%b want 0", nm, busy, mod_freq_valid, mixed_freq_valid);
            end
            n_tests++;
            if (mod_freq !== prev_mf || mixed_freq !== prev_mx) begin
                n_fail++; $display("FAIL %s idle hold got %h/%h want %h/%h", nm, mod_freq, mixed_freq, prev_mf, prev_mx);
            end
            n_tests++;
            if ({dsp.dsp_a, dsp.dsp_b, dsp.dsp_c} !== '0) begin
                n_fail++; $display("FAIL %s idle operands got %h/%h/%h want 0", nm, dsp.dsp_a, dsp.dsp_b, dsp.dsp_c);
            end
            n_tests++;
            if (overrun !== exp_ovr) begin n_fail++; $display("FAIL %s idle overrun got %b want %b", nm, overrun, exp_ovr); end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        prev_mf = '0; prev_mx = '0; exp_ovr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        sample_tick = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({mod_freq, mixed_freq} !== '0) begin n_fail++; $display("FAIL reset freqs got %h/%h want 0", mod_freq, mixed_freq); end
        n_tests++;
        if ({mod_freq_valid, mixed_freq_valid, busy, overrun} !== 4'b0) begin
            n_fail++; $display("FAIL reset flags got %b want 0000", {mod_freq_valid, mixed_freq_valid, busy, overrun});
        end
        n_tests++;
        if ({dsp.dsp_a, dsp.dsp_b, dsp.dsp_c} !== '0) begin n_fail++; $display("FAIL reset operands got %h/%h/%h want 0", dsp.dsp_a, dsp.dsp_b, dsp.dsp_c); end
        sample_tick = 1'b0;
        reset = 1'b1;
        idle(2, "post_reset");
    endtask

    task automatic test_latency();
        run_sample(24'h06E000, 16'h2000, 16'h0400, 24'h000000, -1, -1, "latency");
        n_tests++;
        if (mod_freq !== 24'h037000) begin n_fail++; $display("FAIL latency mod_freq got %h want 037000", mod_freq); end
        n_tests++;
        if (mixed_freq !== 24'h037000) begin n_fail++; $display("FAIL latency mixed_freq got %h want 037000", mixed_freq); end
        idle(2, "latency");
    endtask

    task automatic test_half_amp();
        run_sample(24'h06E000, 16'h2000, 16'h0400, 24'h800000, -1, -1, "half_amp");
        n_tests++;
        if (mixed_freq !== 24'h06E000) begin n_fail++; $display("FAIL half_amp mixed_freq got %h want 06E000", mixed_freq); end
        idle(2, "half_amp");
    endtask

    task automatic test_overrun();
        run_sample(24'($urandom), 16'($urandom), 16'($urandom), 24'($urandom), 6, -1, "overrun");
        idle(N + 2, "overrun_drop");
        n_tests++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun sticky got %b want 1", overrun); end
        do_reset();
        idle(2, "overrun_clear");
    endtask

    task automatic test_back_to_back();
        run_sample(24'($urandom), 16'($urandom), 16'($urandom), 24'($urandom), N - 1, -1, "b2b_first");
        run_sample(24'($urandom), 16'($urandom), 16'($urandom), 24'($urandom), -1, -1, "b2b_second");
        idle(2, "b2b");
        do_reset();
        idle(1, "b2b_clear");
    endtask

    task automatic test_reset_abort();
        fundamental = 24'($urandom); harmonicity = 16'($urandom);
        mod_index = 16'($urandom); mod_sig = 24'($urandom);
        sample_tick = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            sample_tick = 1'b0;
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({mod_freq, mixed_freq, mod_freq_valid, mixed_freq_valid, busy} !== '0) begin
            n_fail++; $display("FAIL abort outputs got %h/%h/%b/%b/%b want 0", mod_freq, mixed_freq, mod_freq_valid, mixed_freq_valid, busy);
        end
        reset = 1'b1;
        prev_mf = '0; prev_mx = '0; exp_ovr = 1'b0;
        idle(L + 6, "abort_quiet");
        run_sample(24'($urandom), 16'($urandom), 16'($urandom), 24'($urandom), -1, -1, "after_abort");
        idle(1, "after_abort");
    endtask

    task automatic test_snapshot();
        run_sample(24'($urandom), 16'($urandom), 16'($urandom), 24'($urandom), -1, L + 3, "snapshot");
        idle(2, "snapshot");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_sample(24'($urandom), 16'($urandom), 16'($urandom), 24'($urandom), -1, -1, "random");
            idle(int'($urandom_range(1, 3)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_half_amp();
        test_overrun();
        test_back_to_back();
        test_reset_abort();
        test_snapshot();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fm_mult_sched.md
FM_MULT_SCHED -- requirements
Module: fm_mult_sched

Interface
REQ-001 SHALL have parameter DSP_LATENCY, default 3, cycles from operands on dsp_a/b/c to the product on dsp_p.
REQ-002 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-004 SHALL have port sample_tick, input, 1, one-cycle request to compute one sample.
REQ-005 SHALL have port fundamental, input, 24, fc in 14.10.
REQ-006 SHALL have port harmonicity, input, 16, in 3.13.
REQ-007 SHALL have port mod_index, input, 16, in 7.9.
REQ-008 SHALL have port mod_sig, input, 24, modulator wavetable sample in 0.24.
REQ-009 SHALL have ports dsp_a, dsp_b, dsp_c, outputs, 24/18/48, operands to the shared DSP48 macro.
REQ-010 SHALL have port dsp_p, input, 48, product P = A*B + C.
REQ-011 SHALL have ports mod_freq and mixed_freq, outputs, 24 each, in 15.9.
REQ-012 SHALL have ports mod_freq_valid and mixed_freq_valid, outputs, 1 each, one-cycle update strobes.
REQ-013 SHALL have port busy, output, 1, high while an operation is in flight.
REQ-014 SHALL have port overrun, output, 1, sticky flag for a dropped tick.

Function
REQ-015 SHALL use FSM states IDLE, OP_FM, OP_D, OP_MIX; IDLE->OP_FM on sample_tick, OP_FM->OP_D->OP_MIX->IDLE on each capture.
REQ-016 SHALL snapshot fundamental, harmonicity, mod_index and mod_sig on the accepting tick; later input changes do not affect the current sample.
REQ-017 SHALL hold operands constant for the whole op; op-cycle counter runs 0..DSP_LATENCY; dsp_p is captured at count==DSP_LATENCY, so each op takes DSP_LATENCY+1 cycles.
REQ-018 OP_FM SHALL drive A=fundamental, B={2'b0,harmonicity}, C=0, and capture mod_freq=P[37:14].
REQ-019 OP_D SHALL drive A=mod_freq, B={2'b0,mod_index}, C=0, and capture depth (internal, 12.6)=P[29:12].
REQ-020 OP_MIX SHALL drive A=mod_sig, B=depth, C={4'b0,fundamental,20'b0}, and capture mixed_freq=P[44:21].
REQ-021 Bit-slice truncation only; no rounding or saturation.
REQ-022 Timing, tick accepted at cycle 0: busy high cycles 1..3*DSP_LATENCY+3; mod_freq updates with mod_freq_valid at cycle DSP_LATENCY+2; mixed_freq updates with mixed_freq_valid at cycle 3*DSP_LATENCY+4.
REQ-023 Outputs hold their last value between strobes.
REQ-024 dsp_a/b/c SHALL be zero in IDLE.
REQ-025 sample_tick is accepted only in IDLE; a tick in any other state, including the final OP_MIX capture cycle, is dropped and sets overrun.
REQ-026 A tick in the first IDLE cycle (same cycle as mixed_freq_valid) SHALL be accepted.
REQ-027 overrun clears only on reset.

Reset
REQ-028 While reset is low at a clock edge: FSM->IDLE, counter=0, and every output including snapshots and depth = 0.
REQ-029 Reset mid-operation SHALL abort the sample, emit no valid strobe, and ignore dsp_p data still in the DSP pipe.
REQ-030 The first tick after reset is released SHALL behave per REQ-022.

Structure
REQ-031 Package fm_pkg SHALL hold the FSM state enum, the width constants (FREQ_W=24, DSP_A_W=24, DSP_B_W=18, DSP_P_W=48) and the slice positions used in REQ-018..REQ-020.
REQ-032 SHALL contain no sub-module; the xbip_dsp48_macro_0 instance sits outside so other blocks can share it.

Verification
REQ-033 Latency test: DSP_LATENCY=3, fundamental=0x06E000 (440.0), harmonicity=0x2000, mod_index=0x0400, mod_sig=0 -> mod_freq=0x037000 at cycle 5; mixed_freq=0x037000 at cycle 13; busy high cycles 1..12.
REQ-034 Half-amplitude modulation: same inputs with mod_sig=0x800000 -> mixed_freq=0x06E000.
REQ-035 Overrun: tick at cycle 0 and again at cycle 6 -> second tick dropped, overrun=1, one mixed_freq_valid only.
REQ-036 Back-to-back boundary: tick at cycle 12 -> dropped with overrun; tick at cycle 13 -> accepted, next mixed_freq_valid at cycle 26.
REQ-037 Reset abort: reset low at cycle 7 of an op -> outputs 0, no valid strobe; a later tick completes correctly.
REQ-038 Snapshot: change fundamental during OP_D -> result matches the value captured at the tick.
